// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: round-robin arbiter sharing the register file write port among NREQ sources
module regfile_wport_arbiter #(
  parameter int NREQ = 3,
  parameter int PW = 3,
  parameter int DCW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [5*NREQ-1:0]  req_addr,
  input  logic [32*NREQ-1:0] req_data,
  output logic               reg_write,
  output logic [4:0]         addr3,
  output logic [31:0]        wdata,
  output logic               busy,
  output logic [DCW-1:0]     drop_cnt
);
  logic [PW-1:0] ptr, ptr_eff, g;
  logic found, hs, drop;
  logic [4:0] sel_addr;
  logic [31:0] sel_data;
  assign ptr_eff = ({1'b0, ptr} >= (PW+1)'(NREQ)) ? '0 : ptr;
  // first pass covers ptr..NREQ-1, second pass wraps around to 0..ptr-1
  always_comb begin
    found = 1'b0;
    g = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (!found && req_valid[i] && PW'(i) >= ptr_eff) begin
        found = 1'b1;
        g = PW'(i);
        sel_addr = req_addr[5*i +: 5];
        sel_data = req_data[32*i +: 32];
      end
    for (int i = 0; i < NREQ; i++)
      if (!found && req_valid[i]) begin
        found = 1'b1;
        g = PW'(i);
        sel_addr = req_addr[5*i +: 5];
        sel_data = req_data[32*i +: 32];
      end
  end
  assign req_ready = (found && !hold && !rst) ? NREQ'(1) << g : '0;
  assign hs = |req_ready;
  assign drop = sel_addr == 5'd0 || sel_addr == 5'd24;
  assign busy = |req_valid && !hs;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      reg_write <= 1'b0;
      addr3 <= '0;
      wdata <= '0;
      drop_cnt <= '0;
    end else begin
      reg_write <= hs && !drop;
      if (hs) begin
        ptr <= (g == PW'(NREQ-1)) ? '0 : g + PW'(1);
        addr3 <= sel_addr;
        wdata <= sel_data;
        if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + DCW'(1);
      end
    end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: vector table plus scoreboard for the write-port arbiter
module tb_regfile_wport_arbiter;
  localparam int N = 3;
  typedef struct {
    logic [2:0]  valid;
    logic        hold;
    logic [14:0] addr;
    logic [95:0] data;
    logic [2:0]  ready;
    logic        busy;
  } vec_t;
  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [7:0]  drop;
  } exp_t;
  localparam logic [14:0] DA = {5'd7, 5'd6, 5'd5};
  localparam logic [95:0] DD = {32'hC, 32'hB, 32'hA};
  logic clk = 0, rst = 1, hold = 0;
  logic [N-1:0] req_valid, req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic reg_write, busy;
  logic [4:0] addr3;
  logic [31:0] wdata;
  logic [7:0] drop_cnt;
  logic [N-1:0] s_valid, s_ready;
  logic [14:0] s_addr;
  logic [95:0] s_data;
  logic s_we, s_busy;
  logic [4:0] s_addr3;
  logic [31:0] s_wdata;
  logic [1:0] s_drop;
  int tests = 0, fails = 0;
  int m_ptr;
  logic [4:0] m_addr;
  logic [31:0] m_data;
  logic [7:0] m_drop;
  exp_t q[$];
  vec_t tbl[22];
  int se[5] = '{1, 2, 3, 3, 3};
  always #5 clk = ~clk;
  regfile_wport_arbiter #(.NREQ(3), .PW(3), .DCW(8)) u_dut (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .reg_write(reg_write), .addr3(addr3),
    .wdata(wdata), .busy(busy), .drop_cnt(drop_cnt));
  regfile_wport_arbiter #(.NREQ(3), .PW(3), .DCW(2)) u_sat (
    .clk(clk), .rst(rst), .hold(1'b0), .req_valid(s_valid), .req_ready(s_ready),
    .req_addr(s_addr), .req_data(s_data), .reg_write(s_we), .addr3(s_addr3),
    .wdata(s_wdata), .busy(s_busy), .drop_cnt(s_drop));
  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  function automatic vec_t mk(input logic [2:0] va, input logic h, input logic [14:0] a,
                              input logic [95:0] d, input logic [2:0] r, input logic b);
    vec_t v;
    v.valid = va; v.hold = h; v.addr = a; v.data = d; v.ready = r; v.busy = b;
    return v;
  endfunction
  task automatic step(input vec_t v);
    int gi;
    exp_t e;
    req_valid = v.valid; hold = v.hold; req_addr = v.addr; req_data = v.data;
    #1;
    chk("req_ready", 96'(req_ready), 96'(v.ready));
    chk("busy", 96'(busy), 96'(v.busy));
    gi = -1;
    if (!v.hold)
      for (int k = 0; k < N; k++)
        if (gi < 0 && v.valid[(m_ptr + k) % N]) gi = (m_ptr + k) % N;
    e.we = 1'b0;
    if (gi >= 0) begin
      m_addr = v.addr[5*gi +: 5];
      m_data = v.data[32*gi +: 32];
      m_ptr = (gi + 1) % N;
      e.we = !(m_addr == 5'd0 || m_addr == 5'd24);
      if (!e.we && m_drop != 8'hFF) m_drop++;
    end
    e.addr = m_addr; e.data = m_data; e.drop = m_drop;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: got empty queue want entry");
    end else begin
      e = q.pop_front();
      chk("reg_write", 96'(reg_write), 96'(e.we));
      chk("addr3", 96'(addr3), 96'(e.addr));
      chk("wdata", 96'(wdata), 96'(e.data));
      chk("drop_cnt", 96'(drop_cnt), 96'(e.drop));
    end
    @(negedge clk);
  endtask
  initial begin
    tbl[0]  = mk(3'b111, 0, DA, DD, 3'b001, 0);
    tbl[1]  = mk(3'b111, 0, DA, DD, 3'b010, 0);
    tbl[2]  = mk(3'b111, 0, DA, DD, 3'b100, 0);
    tbl[3]  = mk(3'b111, 0, DA, DD, 3'b001, 0);
    tbl[4]  = mk(3'b111, 0, DA, DD, 3'b010, 0);
    tbl[5]  = mk(3'b111, 0, DA, DD, 3'b100, 0);
    tbl[6]  = mk(3'b111, 0, DA, DD, 3'b001, 0);
    tbl[7]  = mk(3'b111, 1, DA, DD, 3'b000, 1);
    tbl[8]  = mk(3'b111, 1, DA, DD, 3'b000, 1);
    tbl[9]  = mk(3'b111, 1, DA, DD, 3'b000, 1);
    tbl[10] = mk(3'b111, 0, DA, DD, 3'b010, 0);
    tbl[11] = mk(3'b001, 0, DA, DD, 3'b001, 0);
    tbl[12] = mk(3'b001, 0, DA, DD, 3'b001, 0);
    tbl[13] = mk(3'b000, 0, DA, DD, 3'b000, 0);
    tbl[14] = mk(3'b010, 0, {5'd7, 5'd0, 5'd5}, {32'hC, 32'hFFFF, 32'hA}, 3'b010, 0);
    tbl[15] = mk(3'b010, 0, {5'd7, 5'd24, 5'd5}, {32'hC, 32'hFFFF, 32'hA}, 3'b010, 0);
    tbl[16] = mk(3'b110, 0, DA, DD, 3'b100, 0);
    tbl[17] = mk(3'b110, 0, DA, DD, 3'b010, 0);
    tbl[18] = mk(3'b101, 0, {5'd9, 5'd6, 5'd9}, {32'h22, 32'hB, 32'h11}, 3'b100, 0);
    tbl[19] = mk(3'b101, 0, {5'd9, 5'd6, 5'd9}, {32'h22, 32'hB, 32'h11}, 3'b001, 0);
    tbl[20] = mk(3'b000, 1, DA, DD, 3'b000, 0);
    tbl[21] = mk(3'b100, 1, DA, DD, 3'b000, 1);
    m_ptr = 0; m_addr = '0; m_data = '0; m_drop = '0;
    req_valid = 3'b111; req_addr = DA; req_data = DD;
    s_valid = '0; s_addr = '0; s_data = '1;
    #2;
    chk("rst_ready", 96'(req_ready), 96'(0));
    chk("rst_reg_write", 96'(reg_write), 96'(0));
    chk("rst_drop_cnt", 96'(drop_cnt), 96'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    foreach (tbl[i]) step(tbl[i]);
    req_valid = 3'b111; hold = 0; req_addr = DA; req_data = DD;
    @(posedge clk);
    #1;
    chk("pre_rst_reg_write", 96'(reg_write), 96'(1));
    chk("pre_rst_addr3", 96'(addr3), 96'(6));
    #2;
    rst = 1;
    #1;
    chk("async_rst_reg_write", 96'(reg_write), 96'(0));
    chk("async_rst_addr3", 96'(addr3), 96'(0));
    chk("async_rst_drop_cnt", 96'(drop_cnt), 96'(0));
    chk("async_rst_ready", 96'(req_ready), 96'(0));
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_ready", 96'(req_ready), 96'(3'b001));
    s_valid = 3'b001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("sat_drop_cnt", 96'(s_drop), 96'(se[i]));
      chk("sat_reg_write", 96'(s_we), 96'(0));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
